// File: rtl/carregador_matriz_pkg.sv
// Shared definitions for the matrix loader: element/matrix geometry, legal size range and FSM encoding.
// Latency: none (package only).
// Backpressure: none (package only).
package carregador_matriz_pkg;

  // Width of one signed matrix element, two's complement, stored bit-exact.
  localparam int CM_ELEM_W = 8;

  // Largest and smallest matrix dimension accepted by the loader.
  localparam int CM_N_MAX  = 5;
  localparam int CM_N_MIN  = 2;

  // Flat matrix vector consumed by the transpose/arithmetic operators.
  localparam int CM_MAT_W  = CM_N_MAX * CM_N_MAX * CM_ELEM_W;

  // Width of the size input and of the row/column counters (holds 0..7).
  localparam int CM_CNT_W  = 3;

  // Loader states: idle, filling the matrix, holding a finished matrix.
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CARREGA = 2'd1,
    PRONTO  = 2'd2
  } estado_t;

  // True when a requested dimension lies in the supported range.
  function automatic logic tamanho_valido(input logic [CM_CNT_W-1:0] n);
    return (n >= CM_CNT_W'(CM_N_MIN)) && (n <= CM_CNT_W'(CM_N_MAX));
  endfunction

endpackage

// File: rtl/carregador_matriz.sv
// Loads an NxN (N=2..5) matrix of signed elements, row-major, into a zero-padded flat 5x5 vector.
// Latency: out_valid rises 1 cycle after the final (N-1,N-1) element is accepted.
// Backpressure: in_ready only while loading; finished matrix held with out_valid until out_ready.
module carregador_matriz
  import carregador_matriz_pkg::*;
#(
  parameter int ELEM_W = CM_ELEM_W,
  parameter int N_MAX  = CM_N_MAX
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [CM_CNT_W-1:0]           tamanho,
  input  logic                          in_valid,
  input  logic signed [ELEM_W-1:0]      in_data,
  output logic                          in_ready,
  output logic [N_MAX*N_MAX*ELEM_W-1:0] matrix_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          erro
);

  localparam int N_SLOTS = N_MAX * N_MAX;
  localparam int SLOT_W  = $clog2(N_SLOTS);
  localparam int MAT_W   = N_SLOTS * ELEM_W;

  estado_t                estado_q;
  logic [CM_CNT_W-1:0]    lin_q;
  logic [CM_CNT_W-1:0]    col_q;
  logic [CM_CNT_W-1:0]    tam_q;
  logic                   out_valid_q;
  logic                   erro_q;
  logic [MAT_W-1:0]       mat_q;
  logic [MAT_W-1:0]       mat_d;

  logic                   aceita;
  logic                   inicio_ok;
  logic                   ultima_col;
  logic                   ultima_lin;
  logic [SLOT_W-1:0]      slot_wr;

  // Slot of element (l,c) inside the padded 5x5 layout: rows are always N_MAX wide,
  // so a smaller matrix leaves the tail of each row and the trailing rows at zero.
  function automatic logic [SLOT_W-1:0] slot_de(input logic [CM_CNT_W-1:0] l,
                                                input logic [CM_CNT_W-1:0] c);
    return SLOT_W'(l) * SLOT_W'(N_MAX) + SLOT_W'(c);
  endfunction

  // Loading is open exactly while in CARREGA; no other state takes data.
  assign in_ready   = (estado_q == CARREGA);
  assign aceita     = in_valid && in_ready;

  // A start only counts from idle and only with a supported size.
  assign inicio_ok  = (estado_q == OCIOSO) && start && tamanho_valido(tamanho);

  assign ultima_col = (col_q == tam_q - CM_CNT_W'(1));
  assign ultima_lin = (lin_q == tam_q - CM_CNT_W'(1));
  assign slot_wr    = slot_de(lin_q, col_q);

  assign matrix_out = mat_q;
  assign out_valid  = out_valid_q;
  assign erro       = erro_q;

  // Matrix next-state: cleared on a new load, one slot written per accepted element, otherwise held.
  always_comb begin
    mat_d = mat_q;
    if (inicio_ok) begin
      mat_d = '0;
    end else if (aceita) begin
      for (int s = 0; s < N_SLOTS; s++) begin
        if (slot_wr == SLOT_W'(s)) begin
          mat_d[s*ELEM_W +: ELEM_W] = in_data;
        end
      end
    end
  end

  // Matrix storage register.
  always_ff @(posedge clk) begin
    if (reset) begin
      mat_q <= '0;
    end else begin
      mat_q <= mat_d;
    end
  end

  // Control FSM: size latch, row/column walk, output valid and the illegal-size pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      lin_q       <= '0;
      col_q       <= '0;
      tam_q       <= '0;
      out_valid_q <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      erro_q <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          out_valid_q <= 1'b0;
          if (start) begin
            if (tamanho_valido(tamanho)) begin
              tam_q    <= tamanho;
              lin_q    <= '0;
              col_q    <= '0;
              estado_q <= CARREGA;
            end else begin
              erro_q   <= 1'b1;
            end
          end
        end

        CARREGA: begin
          // Stalled cycles (in_valid low) leave counters untouched.
          if (aceita) begin
            if (ultima_col) begin
              col_q <= '0;
              if (ultima_lin) begin
                estado_q    <= PRONTO;
                out_valid_q <= 1'b1;
              end else begin
                lin_q <= lin_q + CM_CNT_W'(1);
              end
            end else begin
              col_q <= col_q + CM_CNT_W'(1);
            end
          end
        end

        PRONTO: begin
          // Matrix stays put; the operator stage releases it with out_ready.
          if (out_ready) begin
            estado_q    <= OCIOSO;
            out_valid_q <= 1'b0;
          end
        end

        default: begin
          estado_q    <= OCIOSO;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_carregador_matriz.sv
// Directed bench for the matrix loader with a queue-based scoreboard on the output handshake.
module tb_carregador_matriz;
  import carregador_matriz_pkg::*;

  localparam int MW = CM_MAT_W;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [CM_CNT_W-1:0]  tamanho;
  logic                 in_valid;
  logic signed [7:0]    in_data;
  logic                 in_ready;
  logic [MW-1:0]        matrix_out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 erro;

  int                   total = 0;
  int                   bad   = 0;
  logic [MW-1:0]        exp_q [$];
  int                   vals  [25];
  logic [MW-1:0]        snap;

  carregador_matriz dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .tamanho    (tamanho),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .matrix_out (matrix_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .erro       (erro)
  );

  always #5 clk = ~clk;

  task automatic check1(input string nome, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", nome, act, req);
    end
  endtask

  task automatic check8(input string nome, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", nome, act, req);
    end
  endtask

  task automatic checkv(input string nome, input logic [MW-1:0] act, input logic [MW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %050h want %050h", nome, act, req);
    end
  endtask

  // Scoreboard monitor: every output handshake must match the oldest expected matrix.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %050h want no output", matrix_out);
      end else begin
        checkv("scoreboard", matrix_out, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start   = 1'b1;
    tamanho = CM_CNT_W'(n);
    tick();
    start   = 1'b0;
  endtask

  task automatic feed(input int v);
    in_valid = 1'b1;
    in_data  = 8'(v);
    tick();
    in_valid = 1'b0;
  endtask

  // Expected padded vector for an n x n matrix taken from vals[] in row-major order.
  function automatic logic [MW-1:0] esperado(input int n);
    logic [MW-1:0] e;
    e = '0;
    for (int k = 0; k < n*n; k++) begin
      e[((k / n) * 5 + (k % n)) * 8 +: 8] = 8'(vals[k]);
    end
    return e;
  endfunction

  // Back-to-back load of n*n elements from vals[], checking the 1-cycle output latency.
  task automatic load_full(input int n);
    exp_q.push_back(esperado(n));
    do_start(n);
    check1("in_ready_loading", in_ready, 1'b1);
    for (int k = 0; k < n*n - 1; k++) feed(vals[k]);
    in_valid = 1'b1;
    in_data  = 8'(vals[n*n-1]);
    check1("out_valid_before_last", out_valid, 1'b0);
    tick();
    in_valid = 1'b0;
    check1("out_valid_after_last", out_valid, 1'b1);
    check1("in_ready_pronto", in_ready, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    tamanho   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    checkv("reset_matrix", matrix_out, '0);
    check1("reset_in_ready", in_ready, 1'b0);
    check1("reset_out_valid", out_valid, 1'b0);
    check1("reset_erro", erro, 1'b0);
    reset = 1'b0;
    tick();

    // 5x5 with 1..25
    for (int k = 0; k < 25; k++) vals[k] = k + 1;
    load_full(5);
    check8("5x5_slot0", matrix_out[7:0], 8'd1);
    check8("5x5_slot4", matrix_out[39:32], 8'd5);
    check8("5x5_slot24", matrix_out[199:192], 8'd25);
    tick();
    check1("5x5_out_valid_drop", out_valid, 1'b0);

    // 3x3 with -1..-9 and zero padding
    for (int k = 0; k < 9; k++) vals[k] = -(k + 1);
    load_full(3);
    check8("3x3_slot0", matrix_out[7:0], 8'hFF);
    check8("3x3_slot2", matrix_out[23:16], 8'hFD);
    check8("3x3_slot5", matrix_out[47:40], 8'hFC);
    check8("3x3_slot12", matrix_out[103:96], 8'hF7);
    check8("3x3_slot3", matrix_out[31:24], 8'h00);
    check8("3x3_slot9", matrix_out[79:72], 8'h00);
    checkv("3x3_slots15_24", {80'h0, matrix_out[199:120]}, '0);
    tick();

    // Illegal sizes: one-cycle erro, nothing else changes
    snap = matrix_out;
    do_start(1);
    check1("ill1_erro", erro, 1'b1);
    check1("ill1_in_ready", in_ready, 1'b0);
    tick();
    check1("ill1_erro_drop", erro, 1'b0);
    checkv("ill1_matrix", matrix_out, snap);
    do_start(6);
    check1("ill6_erro", erro, 1'b1);
    check1("ill6_in_ready", in_ready, 1'b0);
    tick();
    check1("ill6_erro_drop", erro, 1'b0);
    check1("ill6_in_ready_idle", in_ready, 1'b0);
    checkv("ill6_matrix", matrix_out, snap);

    // 2x2 with a 3-cycle stall, then 5 cycles of backpressure with start pulses
    out_ready = 1'b0;
    vals[0] = 10; vals[1] = 20; vals[2] = 30; vals[3] = 40;
    exp_q.push_back(esperado(2));
    do_start(2);
    feed(10);
    feed(20);
    for (int i = 0; i < 3; i++) tick();
    check1("stall_in_ready", in_ready, 1'b1);
    check1("stall_out_valid", out_valid, 1'b0);
    feed(30);
    feed(40);
    check1("2x2_out_valid", out_valid, 1'b1);
    check8("2x2_slot0", matrix_out[7:0], 8'd10);
    check8("2x2_slot1", matrix_out[15:8], 8'd20);
    check8("2x2_slot5", matrix_out[47:40], 8'd30);
    check8("2x2_slot6", matrix_out[55:48], 8'd40);
    snap = matrix_out;
    for (int i = 0; i < 5; i++) begin
      start   = 1'b1;
      tamanho = (i % 2 == 0) ? 3'd3 : 3'd7;
      tick();
      check1("hold_out_valid", out_valid, 1'b1);
      check1("hold_in_ready", in_ready, 1'b0);
      check1("hold_erro", erro, 1'b0);
      checkv("hold_matrix", matrix_out, snap);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    check1("release_out_valid", out_valid, 1'b0);
    check1("release_in_ready", in_ready, 1'b0);
    checkv("release_matrix_kept", matrix_out, snap);

    // Reset after 7 of 25 elements, then a clean 5x5 load
    do_start(5);
    for (int k = 0; k < 7; k++) feed(k + 50);
    reset = 1'b1;
    tick();
    checkv("midreset_matrix", matrix_out, '0);
    check1("midreset_in_ready", in_ready, 1'b0);
    check1("midreset_out_valid", out_valid, 1'b0);
    reset = 1'b0;
    tick();
    for (int k = 0; k < 25; k++) vals[k] = (k % 2 == 0) ? (k + 1) : -((k + 1) * 3);
    load_full(5);
    check8("fresh_slot1", matrix_out[15:8], 8'hFA);
    check8("fresh_slot24", matrix_out[199:192], 8'd25);
    tick();

    // Drain: every expected matrix must have been seen, within a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check1("scoreboard_drained", exp_q.size() == 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/carregador_matriz.md
Name: carregador_matriz

Overview:
- Sequential input stage directly upstream of the 5x5 transpose/arithmetic operators.
- Accepts signed 8-bit matrix elements one per cycle over a valid/ready stream in row-major order, for a programmable size NxN (N = 2..5).
- Assembles the elements into the flat 200-bit matrix vector the operators consume.
- Presents that vector with an out_valid/out_ready handshake. The vector is held stable until the operator stage accepts it.

Parameters:
- ELEM_W, 8, width of one signed matrix element in bits.
- N_MAX, 5, maximum matrix dimension. The flat vector is N_MAX*N_MAX*ELEM_W = 200 bits.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin loading a new matrix.
- tamanho  in  3  matrix dimension N; sampled only on an accepted start.
- in_valid  in  1  in_data holds a valid element.
- in_data  in  ELEM_W  signed element, row-major order.
- in_ready  out  1  block accepts in_data this cycle.
- matrix_out  out  N_MAX*N_MAX*ELEM_W  assembled matrix; element (i,j) at bits [(i*5+j)*8 +: 8].
- out_valid  out  1  matrix_out is complete and stable.
- out_ready  in  1  downstream operator consumes matrix_out.
- erro  out  1  one-cycle pulse: start received with an illegal tamanho.

Behaviour:
- Reset (synchronous, any state, including mid-load or mid-hold):
  - State goes to OCIOSO.
  - matrix_out, row counter lin and column counter col go to 0; the latched size goes to 0.
  - in_ready, out_valid and erro go to 0.
- FSM states: OCIOSO, CARREGA, PRONTO.
- OCIOSO:
  - in_ready=0, out_valid=0.
  - start=1 with 2<=tamanho<=5: latch the size, clear matrix_out to all zeros, set lin=col=0, go to CARREGA next cycle.
  - start=1 with tamanho outside 2..5: erro=1 for exactly the next cycle; stay in OCIOSO; matrix_out unchanged.
- CARREGA:
  - in_ready=1 combinationally from state.
  - An element is accepted when in_valid=1 and in_ready=1.
  - On accept, write in_data to slot (lin*5+col). col increments; when col = N-1 it wraps to 0 and lin increments.
  - Slots with row or column >= N remain 0 (zero padding), so the operators always see a valid 5x5.
  - in_valid=0 cycles stall the load without side effects.
  - start is ignored while in CARREGA.
  - Accepting the element at (N-1,N-1): go to PRONTO. out_valid=1 on the cycle after that accept (latency 1 cycle from the final element).
- PRONTO:
  - in_ready=0, out_valid=1, matrix_out held constant.
  - out_ready=1: return to OCIOSO next cycle and drop out_valid. matrix_out keeps its value until the next accepted start.
  - start is ignored in PRONTO.
- Values are stored bit-exact as two's complement; no sign extension or arithmetic is performed.
- Element count per matrix is exactly N*N. A full 5x5 needs 25 accepts, so the minimum time from start to out_valid is 27 cycles.

Decomposition:
- Shared package: ELEM_W, N_MAX, matrix vector width, the FSM state encoding (OCIOSO/CARREGA/PRONTO), and the legal size bounds (N_MIN=2, N_MAX=5).
- No sub-module is needed. The slot write decoder (lin*5+col) is an internal function of the block.

Test Plan:
- 5x5 load: start with tamanho=5, then feed 1..25 back-to-back.
  - out_valid rises 1 cycle after the 25th accept.
  - matrix_out[7:0]=1, matrix_out[39:32]=5, matrix_out[199:192]=25.
  - Output is the exact vector expected by the transpose stage.
- 3x3 with padding: tamanho=3, feed -1..-9 (0xFF..0xF7).
  - Slot 0 = 0xFF, slot 2 = 0xFD, slot 5 = 0xFC, slot 12 = 0xF7.
  - Slots 3, 4, 8, 9 and 15..24 are 0x00.
- Illegal size: start with tamanho=1, then tamanho=6.
  - Each produces erro=1 for exactly one cycle.
  - State stays OCIOSO, in_ready stays 0, matrix_out unchanged.
- Stall and backpressure: 2x2 load with in_valid deasserted for 3 cycles between elements 2 and 3.
  - Matrix is correct: slots 0, 1, 5, 6 = 10, 20, 30, 40.
  - out_ready held 0 for 5 cycles: out_valid stays 1 and matrix_out stays stable.
  - start pulses during PRONTO are ignored.
- Reset mid-load: assert reset after 7 of 25 elements.
  - Next cycle: matrix_out=0, in_ready=0, out_valid=0.
  - A fresh 5x5 load afterwards completes correctly with no residue from the aborted load.
